// File: rtl/traffic_intersection_fsm.sv
// Two-road intersection controller: main/side lights, demand-driven side phase,
// latched pedestrian request with walk output, and night flashing mode.
module traffic_intersection_fsm #(
  parameter int unsigned T_GREEN_MAIN = 8,
  parameter int unsigned T_GREEN_SIDE = 4,
  parameter int unsigned T_YELLOW     = 2,
  parameter int unsigned T_ALL_RED    = 1,
  parameter int unsigned T_FLASH      = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_sensor,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    FLASH       = 3'd6,
    UNUSED      = 3'd7
  } state_t;

  // Timer reload values (duration - 1); a duration of 2^CNT_W loads all-ones.
  localparam logic [CNT_W-1:0] LD_GM = CNT_W'(T_GREEN_MAIN - 1);
  localparam logic [CNT_W-1:0] LD_GS = CNT_W'(T_GREEN_SIDE - 1);
  localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_AR = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] LD_FL = CNT_W'(T_FLASH - 1);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  state_t           state, nxt;
  logic [CNT_W-1:0] timer, load_val;
  logic             ped_pending, blink;
  logic             timer_zero, enter_side;

  assign timer_zero = (timer == '0);
  assign enter_side = (nxt == SIDE_GREEN) && (state != SIDE_GREEN);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= MAIN_GREEN;
    else        state <= nxt;
  end

  // Next-state selection and the timer value loaded on entry to that state.
  always_comb begin
    nxt = state;
    if (flash_mode) begin
      nxt = FLASH;
    end else begin
      case (state)
        MAIN_GREEN:  if (timer_zero && (side_sensor || ped_pending)) nxt = MAIN_YELLOW;
        MAIN_YELLOW: if (timer_zero) nxt = ALL_RED_A;
        ALL_RED_A:   if (timer_zero) nxt = SIDE_GREEN;
        SIDE_GREEN:  if (timer_zero) nxt = SIDE_YELLOW;
        SIDE_YELLOW: if (timer_zero) nxt = ALL_RED_B;
        ALL_RED_B:   if (timer_zero) nxt = MAIN_GREEN;
        default:     nxt = ALL_RED_B;  // FLASH exit and unused code 7
      endcase
    end
    case (nxt)
      MAIN_GREEN:              load_val = LD_GM;
      MAIN_YELLOW,SIDE_YELLOW: load_val = LD_Y;
      SIDE_GREEN:              load_val = LD_GS;
      FLASH:                   load_val = LD_FL;
      default:                 load_val = LD_AR;
    endcase
  end

  // Phase timer, blink generator, pedestrian latch and walk register.
  // In FLASH the timer free-runs over the blink half-period instead of holding at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer       <= LD_GM;
      blink       <= 1'b1;
      ped_pending <= 1'b0;
      walk        <= 1'b0;
    end else begin
      if (nxt != state)                   timer <= load_val;
      else if (state == FLASH && timer_zero) timer <= LD_FL;
      else if (!timer_zero)               timer <= timer - CNT_W'(1);

      if (nxt == FLASH && state != FLASH)                  blink <= 1'b1;
      else if (nxt == FLASH && state == FLASH && timer_zero) blink <= ~blink;

      ped_pending <= ped_req | (ped_pending & ~enter_side);

      if (enter_side)             walk <= ped_pending;
      else if (nxt != SIDE_GREEN) walk <= 1'b0;
    end
  end

  // Moore light decode from the state register.
  always_comb begin
    main_light = RED;
    side_light = RED;
    phase      = state;
    case (state)
      MAIN_GREEN:  main_light = GREEN;
      MAIN_YELLOW: main_light = YELLOW;
      SIDE_GREEN:  side_light = GREEN;
      SIDE_YELLOW: side_light = YELLOW;
      FLASH: begin
        main_light = blink ? YELLOW : DARK;
        side_light = blink ? YELLOW : DARK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_intersection_fsm.sv
// Randomized bench for traffic_intersection_fsm against a phase/countdown model.
module tb_traffic_intersection_fsm;

  localparam int TGM = 8, TGS = 4, TY = 2, TAR = 1, TFL = 3;
  localparam int NCYC = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic       side_sensor, ped_req, flash_mode;
  logic [2:0] main_light, side_light, phase;
  logic       walk;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_intersection_fsm #(
    .T_GREEN_MAIN(TGM), .T_GREEN_SIDE(TGS), .T_YELLOW(TY),
    .T_ALL_RED(TAR), .T_FLASH(TFL), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .side_sensor(side_sensor), .ped_req(ped_req),
    .flash_mode(flash_mode), .main_light(main_light), .side_light(side_light),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: phase index plus cycles remaining in that phase (including the current one).
  int dur[7]         = '{TGM, TY, TAR, TGS, TY, TAR, 0};
  int main_tab[7]    = '{1, 2, 4, 4, 4, 4, 0};
  int side_tab[7]    = '{4, 4, 4, 1, 2, 4, 0};
  int m_ph, m_left, m_fleft;
  bit m_ped, m_walk, m_blink;

  function automatic void model_reset();
    m_ph = 0; m_left = TGM; m_ped = 0; m_walk = 0; m_blink = 1; m_fleft = TFL;
  endfunction

  function automatic void model_step(input bit fm, input bit ss, input bit pr);
    int nph;
    bit into_side;
    if (fm)                nph = 6;
    else if (m_ph == 6)    nph = 5;
    else if (m_left > 1)   nph = m_ph;
    else if (m_ph == 0)    nph = (ss || m_ped) ? 1 : 0;
    else                   nph = (m_ph == 5) ? 0 : m_ph + 1;
    into_side = (nph == 3) && (m_ph != 3);
    if (nph == 6) begin
      if (m_ph != 6) begin m_blink = 1; m_fleft = TFL; end
      else if (m_fleft == 1) begin m_blink = !m_blink; m_fleft = TFL; end
      else m_fleft--;
    end
    if (nph != 3)      m_walk = 0;
    else if (into_side) m_walk = m_ped;
    m_ped  = pr || (m_ped && !into_side);
    m_left = (nph != m_ph) ? dur[nph] : ((m_left > 1) ? m_left - 1 : 1);
    m_ph   = nph;
  endfunction

  task automatic compare_all();
    int em, es;
    em = (m_ph == 6) ? (m_blink ? 2 : 0) : main_tab[m_ph];
    es = (m_ph == 6) ? (m_blink ? 2 : 0) : side_tab[m_ph];
    check("main_light", 32'(main_light), 32'(em));
    check("side_light", 32'(side_light), 32'(es));
    check("walk",       32'(walk),       32'(m_walk));
    check("phase",      32'(phase),      32'(m_ph));
    if (m_ph != 6)
      check("safety", 32'((main_light != 3'b100) && (side_light != 3'b100)), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_main"},  32'(main_light), 32'h1);
    check({tag, "_side"},  32'(side_light), 32'h4);
    check({tag, "_walk"},  32'(walk),       32'h0);
    check({tag, "_phase"}, 32'(phase),      32'h0);
  endtask

  initial begin
    bit fm_hold;
    reset = 1'b0; side_sensor = 0; ped_req = 0; flash_mode = 0;
    #2 check_reset_outputs("reset");
    model_reset();
    #5 reset = 1'b1;
    fm_hold = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      compare_all();
      // Occasional asynchronous reset between edges.
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        #1 reset = 1'b1;
      end
      // Quiet stretches keep main green holding; busy stretches drive full cycles.
      if ($urandom_range(0, 59) == 0) fm_hold = !fm_hold;
      flash_mode  = fm_hold;
      side_sensor = (c % 600 < 150) ? 1'b0 : ($urandom_range(0, 3) == 0);
      ped_req     = ($urandom_range(0, 11) == 0);
      @(posedge clk);
      model_step(flash_mode, side_sensor, ped_req);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_fsm.md
# traffic_intersection_fsm

Parametrised two-road intersection controller. It replaces the single-signal traffic light FSM with separate main and side road lights, demand-driven side phases, a latched pedestrian request with walk output, and a night flashing mode. Phase durations and counter width are parameters. It is a self-contained leaf block driven by the system clock; outputs go directly to lamp drivers.

## Interface
- `T_GREEN_MAIN`, 8: minimum main-green duration in cycles (≥1).
- `T_GREEN_SIDE`, 4: side-green duration in cycles (≥1).
- `T_YELLOW`, 2: yellow duration in cycles, both roads (≥1).
- `T_ALL_RED`, 1: all-red clearance duration in cycles (≥1).
- `T_FLASH`, 3: flash half-period in cycles (≥1).
- `CNT_W`, 8: timer width; every duration must be ≤ 2^CNT_W.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low (`reset`=0 resets).
- `side_sensor`  in  1  vehicle waiting on side road, level, sampled every cycle.
- `ped_req`  in  1  pedestrian button, one or more cycles high; latched.
- `flash_mode`  in  1  night mode request, level.
- `main_light`  out  3  {R,Y,G}: 100 red, 010 yellow, 001 green, 000 dark.
- `side_light`  out  3  same encoding.
- `walk`  out  1  pedestrian walk across main road.
- `phase`  out  3  current state code, for debug.

## Operation
- States and codes: MAIN_GREEN 0, MAIN_YELLOW 1, ALL_RED_A 2, SIDE_GREEN 3, SIDE_YELLOW 4, ALL_RED_B 5, FLASH 6.
- Moore outputs, decoded from the state register:
  - MAIN_GREEN: main 001, side 100.
  - MAIN_YELLOW: main 010, side 100.
  - ALL_RED_A/B: both 100.
  - SIDE_GREEN: main 100, side 001.
  - SIDE_YELLOW: main 100, side 010.
  - FLASH: both 010 when `blink`=1, 000 otherwise. `walk`=0.
- Timer is a CNT_W down-counter, loaded with (duration−1) on state entry and decremented each cycle while nonzero.
- A fixed-duration state lasts exactly its duration.
- MAIN_GREEN: on timer==0, moves to MAIN_YELLOW only if `side_sensor`=1 or `ped_pending`=1. Otherwise it holds, timer stays at 0, and exits in the first cycle demand appears.
- Fixed sequence: MAIN_YELLOW → ALL_RED_A → SIDE_GREEN → SIDE_YELLOW → ALL_RED_B → MAIN_GREEN.
- `ped_pending`:
  - Set by `ped_req`=1.
  - Cleared on the clock that enters SIDE_GREEN.
  - If `ped_req`=1 on that same edge, set wins and the request is served in the next cycle.
- `walk` register: loaded on entry to SIDE_GREEN with the pre-edge `ped_pending`. Cleared on exit from SIDE_GREEN.
- FLASH entry: `flash_mode`=1 in any state moves to FLASH on the next edge, with `blink` initialised to 1.
- In FLASH, `blink` toggles every T_FLASH cycles.
- FLASH exit: when `flash_mode`=0, moves to ALL_RED_B, then MAIN_GREEN. `ped_pending` is preserved through FLASH.
- Unused state code 7 goes to ALL_RED_B on the next edge.

## Timing
- Reset (asynchronous assert, any time):
  - state MAIN_GREEN, timer T_GREEN_MAIN−1.
  - `main_light`=001, `side_light`=100, `walk`=0, `ped_pending`=0, `blink`=1, `phase`=0.
- Reset mid-phase aborts immediately with no yellow. Release is synchronous to the next `clk` edge.
- Input-to-output latency: one edge. An input sampled high at edge k changes outputs after edge k.
- Full cycle with constant side demand: T_GREEN_MAIN + 2·T_YELLOW + 2·T_ALL_RED + T_GREEN_SIDE cycles, which is 18 at defaults.
- Safety: main and side are never both non-red outside FLASH, including across any transition.
- Timer and state must not wrap. Parameters of 2^CNT_W load all-ones.

## Test plan
- Reset, no demand, 50 cycles → main 001, side 100 throughout; `phase`=0.
- `side_sensor` high from cycle 2 → main green for 8 cycles, then yellow for 2, red-red for 1, side green for 4, side yellow for 2, red-red for 1, main green; period 18.
- 1-cycle `ped_req` pulse at cycle 3, sensor low → full sequence runs and `walk`=1 for exactly the 4 SIDE_GREEN cycles.
- `ped_req` on the SIDE_GREEN entry edge → `walk`=0 this phase; a second side phase follows with `walk`=1.
- `flash_mode` raised during SIDE_GREEN → next cycle both lights 010; 3 cycles 010, 3 cycles 000, repeating. On drop, 1 cycle red-red, then main 001.
- `reset` pulled low mid SIDE_YELLOW between clock edges → outputs immediately main 001, side 100, `walk` 0.
